sc_bitstream_decoder: RTL and testbench

//  Converts NUM_INPUTS parallel stochastic bitstreams back to WIDTH-bit binary values.
//  It is the receive end of the LFSR stochastic number generator: it counts ones over one

---
 rtl/sc_bitstream_decoder_pkg.sv | 21 ++
 rtl/sc_bitstream_decoder_ones_counter.sv | 22 ++
 rtl/sc_bitstream_decoder.sv | 143 ++++++++++++++
 tb/tb_sc_bitstream_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_bitstream_decoder_pkg.sv
// Shared types and helpers for the stochastic bitstream decoder.
package sc_pkg;

   typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_HOLD} sc_dec_state_t;

   function automatic int unsigned sc_full_len(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

   // Scales an early-terminated ones count back to full range, clamping at all-ones.
   function automatic int unsigned sc_et_scale(input int unsigned ones,
                                               input int unsigned shift,
                                               input int unsigned width);
      int unsigned scaled;
      int unsigned max_val;
      scaled  = ones << shift;
      max_val = sc_full_len(width);
      return (scaled > max_val) ? max_val : scaled;
   endfunction

endpackage

// File: rtl/sc_bitstream_decoder_ones_counter.sv
// Per-lane ones accumulator: synchronous clear wins over enable.
module sc_ones_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + WIDTH'(bit_in);
   end

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream to binary decoder with valid/ready result hold.
// Optional early termination is compiled in with SC_ET_EN.
//
// state   | meaning
// SC_IDLE | waiting for start, last result still on Bzs
// SC_RUN  | accumulating valid samples until LEN reached
// SC_HOLD | result valid, waiting for out_ready
module sc_bitstream_decoder
   import sc_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int NUM_INPUTS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [NUM_INPUTS-1:0] Xs,
`ifdef SC_ET_EN
   input  logic [$clog2(WIDTH+1)-1:0] et_log2,
`endif
   output logic [WIDTH-1:0]      Bzs [NUM_INPUTS-1:0],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   sc_dec_state_t    state_q, state_d;
   logic             start_acc;
   logic             sample;
   logic             last;
   logic [WIDTH-1:0] remain_q;
   logic [WIDTH-1:0] len_m1;
   logic [WIDTH-1:0] ones  [NUM_INPUTS];
   logic [WIDTH-1:0] tally [NUM_INPUTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= SC_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      case (state_q)
         SC_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_d   = SC_RUN;
            end
         end
         SC_RUN: begin
            if (in_valid && remain_q == '0)
               state_d = SC_HOLD;
         end
         SC_HOLD: begin
            if (out_ready) begin
               if (start) begin
                  start_acc = 1'b1;
                  state_d   = SC_RUN;
               end else begin
                  state_d = SC_IDLE;
               end
            end
         end
         default: state_d = SC_IDLE;
      endcase
   end

   assign sample    = (state_q == SC_RUN) && in_valid;
   assign last      = sample && (remain_q == '0);
   assign busy      = (state_q == SC_RUN);
   assign out_valid = (state_q == SC_HOLD);

`ifdef SC_ET_EN
   localparam int ETW = $clog2(WIDTH+1);
   logic [ETW-1:0] et_q;
   int unsigned    shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         et_q <= '0;
      else if (start_acc)
         et_q <= et_log2;
   end

   // Length is decided from the live port at the accept edge; scaling uses the latched copy.
   always_comb begin
      len_m1 = WIDTH'(sc_full_len(WIDTH) - 32'd1);
      if (et_log2 < ETW'(WIDTH))
         len_m1 = WIDTH'((32'd1 << et_log2) - 32'd1);
      shift = 32'd0;
      if (et_q < ETW'(WIDTH))
         shift = 32'(WIDTH) - 32'(et_q);
   end
`else
   assign len_m1 = WIDTH'(sc_full_len(WIDTH) - 32'd1);
`endif

   // Down-counter of samples still owed; terminal count marks the final sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         remain_q <= '0;
      else if (start_acc)
         remain_q <= len_m1;
      else if (sample && remain_q != '0)
         remain_q <= remain_q - 1'b1;
   end

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
      sc_ones_counter #(.WIDTH(WIDTH)) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (start_acc),
         .en     (sample),
         .bit_in (Xs[i]),
         .count  (ones[i])
      );
   end

   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++)
         tally[i] = ones[i] + WIDTH'(Xs[i]);
   end

   // Result register is separate from the counters so Bzs survives the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_INPUTS; i++)
            Bzs[i] <= '0;
      end else if (last) begin
         for (int i = 0; i < NUM_INPUTS; i++)
`ifdef SC_ET_EN
            Bzs[i] <= WIDTH'(sc_et_scale(32'(tally[i]), shift, WIDTH));
`else
            Bzs[i] <= tally[i];
`endif
      end
   end

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Self-checking bench for sc_bitstream_decoder; early-termination cases run when SC_ET_EN is defined.
module tb_sc_bitstream_decoder;

   localparam int W = 8;
   localparam int N = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [N-1:0] Xs = '0;
   logic [3:0]   et_log2 = 4'd8;
   logic [W-1:0] Bzs [N-1:0];
   logic         out_valid;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;
   int last_exp [N];
   int lat;

   always #5 clk = ~clk;

   sc_bitstream_decoder #(.WIDTH(W), .NUM_INPUTS(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .Xs        (Xs),
`ifdef SC_ET_EN
      .et_log2   (et_log2),
`endif
      .Bzs       (Bzs),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: ones over LEN samples, scaled by 2^(W-et) and clamped when terminated early.
   function automatic int ref_val(input int ones, input int et);
      int v;
      if (et < W) begin
         v = ones * (2 ** (W - et));
         return (v > 255) ? 255 : v;
      end
      return ones;
   endfunction

   // mode: 0 LFSR lanes (Bx=0x80>>lane), 1 ones, 2 zeros, 3 random, 4 alternating 1010..
   task automatic run_conv(input int mode, input bit gap, input int et, input bit do_start,
                           output int latency);
      int         len;
      int         acc;
      int         ones [N];
      logic [7:0] lfsr;
      bit         done;
      len  = (et < W) ? (1 << et) : 255;
      acc  = 0;
      lfsr = 8'h01;
      done = 1'b0;
      for (int i = 0; i < N; i++) ones[i] = 0;
      latency = 0;
      if (do_start) begin
         et_log2 = 4'(et);
         start   = 1'b1;
         step();
         start   = 1'b0;
      end
      for (int c = 1; c <= 1200 && !done; c++) begin
         in_valid = gap ? (c % 2 == 0) : 1'b1;
         start    = (c == 3);
         case (mode)
            0: for (int i = 0; i < N; i++) Xs[i] = (lfsr < (8'h80 >> i));
            1: Xs = '1;
            2: Xs = '0;
            3: Xs = N'($urandom);
            4: Xs = (acc % 2 == 0) ? '1 : '0;
            default: Xs = '0;
         endcase
         if (in_valid) begin
            for (int i = 0; i < N; i++) ones[i] += int'(Xs[i]);
            acc++;
            lfsr = {lfsr[6:0], 1'b0} ^ (lfsr[7] ? 8'h1D : 8'h00);
         end else begin
            Xs = N'($urandom);
         end
         step();
         latency = c;
         if (acc == len) done = 1'b1;
         if (c == 1 && len > 1) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_no_valid", 32'(out_valid), 32'd0);
         end
      end
      start    = 1'b0;
      in_valid = 1'b0;
      check("conv_done", 32'(done), 32'd1);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
      for (int i = 0; i < N; i++) begin
         last_exp[i] = ref_val(ones[i], et);
         check($sformatf("bz_lane%0d_mode%0d_et%0d", i, mode, et), 32'(Bzs[i]), 32'(last_exp[i]));
      end
   endtask

   task automatic release_idle();
      out_ready = 1'b1;
      start     = 1'b0;
      step();
      out_ready = 1'b0;
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      for (int i = 0; i < N; i++)
         check("idle_bz_kept", 32'(Bzs[i]), 32'(last_exp[i]));
   endtask

   initial begin
      rst_n = 1'b0;
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < N; i++) check("rst_bz", 32'(Bzs[i]), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // LFSR generator, Bx=0x80 on lane 0
      run_conv(0, 1'b0, 8, 1'b1, lat);
      check("lfsr_latency", 32'(lat), 32'd255);
      check("lfsr_bz0_const", 32'(Bzs[0]), 32'h7F);

      // HOLD stability with ignored start and noise, then back-to-back restart
      for (int k = 0; k < 10; k++) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom);
         Xs        = N'($urandom);
         start     = (k == 5);
         step();
         check("stall_valid", 32'(out_valid), 32'd1);
         for (int i = 0; i < N; i++) check("stall_bz", 32'(Bzs[i]), 32'(last_exp[i]));
      end
      in_valid  = 1'b0;
      et_log2   = 4'd8;
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      out_ready = 1'b0;
      start     = 1'b0;
      check("b2b_valid", 32'(out_valid), 32'd0);
      check("b2b_busy", 32'(busy), 32'd1);
      run_conv(1, 1'b0, 8, 1'b0, lat);
      check("ones_bz_const", 32'(Bzs[0]), 32'hFF);
      release_idle();

      run_conv(2, 1'b0, 8, 1'b1, lat);
      release_idle();
      for (int r = 0; r < 3; r++) begin
         run_conv(3, 1'b0, 8, 1'b1, lat);
         release_idle();
      end

      // in_valid toggling stretches latency to twice LEN
      run_conv(0, 1'b1, 8, 1'b1, lat);
      check("gap_latency", 32'(lat), 32'd510);
      release_idle();
      run_conv(3, 1'b0, 8, 1'b1, lat);
      release_idle();

      // asynchronous reset partway through a run
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         in_valid = 1'b1;
         Xs       = N'($urandom);
         step();
      end
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < N; i++) check("arst_bz", 32'(Bzs[i]), 32'd0);
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      run_conv(0, 1'b0, 8, 1'b1, lat);
      check("post_rst_latency", 32'(lat), 32'd255);
      release_idle();

`ifdef SC_ET_EN
      run_conv(4, 1'b0, 4, 1'b1, lat);
      check("et4_alt_const", 32'(Bzs[0]), 32'h80);
      check("et4_latency", 32'(lat), 32'd16);
      release_idle();
      run_conv(1, 1'b0, 4, 1'b1, lat);
      check("et4_sat_const", 32'(Bzs[1]), 32'hFF);
      release_idle();
      run_conv(0, 1'b0, 8, 1'b1, lat);
      check("et8_latency", 32'(lat), 32'd255);
      release_idle();
      run_conv(1, 1'b0, 0, 1'b1, lat);
      release_idle();
      run_conv(2, 1'b0, 0, 1'b1, lat);
      release_idle();
      run_conv(3, 1'b0, 3, 1'b1, lat);
      release_idle();
      run_conv(3, 1'b1, 5, 1'b1, lat);
      release_idle();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
